// File: rtl/booth_pkg.sv
// Shared radix-4 Booth definitions: recode operations, FSM states, triplet decode.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_op_e;

  typedef enum logic {IDLE, RUN} booth_state_e;

  // Map {Q[1],Q[0],Q[-1]} to the partial-product operation.
  function automatic booth_op_e booth_decode(input logic [2:0] t);
    booth_op_e op;
    case (t)
      3'b000, 3'b111: op = ZERO;
      3'b001, 3'b010: op = POS1;
      3'b011:         op = POS2;
      3'b100:         op = NEG2;
      default:        op = NEG1;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational Booth recode of one triplet into a signed partial product of the multiplicand.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] m,
  input  logic [2:0]   triplet,
  output logic [W-1:0] pp_c
);

  booth_op_e op;

  assign op = booth_decode(triplet);

  always_comb begin
    pp_c = '0;
    case (op)
      ZERO:    pp_c = '0;
      POS1:    pp_c = m;
      POS2:    pp_c = m << 1;
      NEG1:    pp_c = -m;
      NEG2:    pp_c = -(m << 1);
      default: pp_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, one step per clock.
// Optional BOOTH_UNSIGNED_EN adds is_signed and one extra step for unsigned operands.
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
`ifdef BOOTH_UNSIGNED_EN
  input  logic           is_signed,
`endif
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int unsigned STEPS = N / 2 + 1;
  localparam int unsigned QW    = N + 2;
`else
  localparam int unsigned STEPS = N / 2;
  localparam int unsigned QW    = N;
`endif
  localparam int unsigned AW    = N + 2;
  localparam int unsigned CW    = AW + QW + 1;
  localparam int unsigned CNTW  = $clog2(STEPS + 1);

  booth_state_e     state_q, state_d;
  logic [AW-1:0]    m_q, m_d, acc_q, acc_d, pp, sum;
  logic [QW-1:0]    q_q, q_d, q_load;
  logic             qm1_q, qm1_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0]   product_d;
  logic             busy_d, done_d;
  logic [AW-1:0]    m_load;
  logic [CW-1:0]    shifted;

  // Operand extension: unsigned mode widens Q by two bits so the final step sees a zero/sign triplet.
`ifdef BOOTH_UNSIGNED_EN
  assign m_load = {{2{is_signed & multiplicand[N-1]}}, multiplicand};
  assign q_load = {{2{is_signed & multiplier[N-1]}}, multiplier};
`else
  assign m_load = {{2{multiplicand[N-1]}}, multiplicand};
  assign q_load = multiplier;
`endif

  booth_r4_recoder #(.W(AW)) u_recoder (
    .m       (m_q),
    .triplet ({q_q[1:0], qm1_q}),
    .pp_c    (pp)
  );

  assign sum     = acc_q + pp;
  assign shifted = $signed({sum, q_q, qm1_q}) >>> 2;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product;
    busy_d    = busy;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          m_d       = m_load;
          acc_d     = '0;
          q_d       = q_load;
          qm1_d     = 1'b0;
          cnt_d     = '0;
          product_d = '0;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        acc_d = shifted[CW-1 -: AW];
        q_d   = shifted[QW:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(STEPS - 1)) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = shifted[2*N:1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      product <= product_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier (N=8): vector table, corner sequences, random ops.
module tb_booth_radix4_multiplier;

  localparam int N = 8;
`ifdef BOOTH_UNSIGNED_EN
  localparam int STEPS = N / 2 + 1;
`else
  localparam int STEPS = N / 2;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [N-1:0]  multiplicand, multiplier;
  logic          is_signed;
  logic [2*N-1:0] product;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_radix4_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed    (is_signed),
`endif
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sgn;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[9];

  // Reference: plain integer product, truncated to 2N bits.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int x, y;
    x = sgn ? int'($signed(a)) : int'(a);
    y = sgn ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Called just after the accepting edge; returns edges until done and busy-high cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check("done_within_bound", 32'(done), 32'd1);
  endtask

  int lat, bcnt, ndone;
  logic [15:0] cap;
  logic [7:0] ra, rb;
  bit rs;

  initial begin
    tbl[0] = '{8'h07, 8'hFD, 1'b1, 16'hFFEB};
    tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 16'h0000};
    tbl[4] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[5] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[6] = '{8'h01, 8'h80, 1'b1, 16'hFF80};
    tbl[7] = '{8'h03, 8'h04, 1'b1, 16'h000C};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};

    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0; is_signed = 1'b1;
    tick(); tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst = 1'b0;
    tick();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      is_signed = tbl[i].sgn;
      issue(tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d_busy_on_accept", i), 32'(busy), 32'd1);
      wait_done(lat, bcnt);
      check($sformatf("vec%0d_product", i), 32'(product), 32'(tbl[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(STEPS));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(STEPS));
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
      tick();
      check($sformatf("vec%0d_done_pulse_ends", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_product_held", i), 32'(product), 32'(tbl[i].exp));
    end

    // Back-to-back: new start held high in the done cycle
    is_signed = 1'b1;
    issue(8'h80, 8'h80);
    wait_done(lat, bcnt);
    check("b2b_first_product", 32'(product), 32'h4000);
    multiplicand = 8'h80; multiplier = 8'h7F; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accept_done_low", 32'(done), 32'd0);
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_accept_product_cleared", 32'(product), 32'd0);
    wait_done(lat, bcnt);
    check("b2b_second_product", 32'(product), 32'hC080);
    check("b2b_second_latency", 32'(lat), 32'(STEPS));
    tick();

    // Start during busy is ignored
    issue(8'h07, 8'hFD);
    tick();
    multiplicand = 8'h05; multiplier = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; cap = '0;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        ndone++;
        cap = product;
      end
      tick();
    end
    check("ignored_start_done_count", 32'(ndone), 32'd1);
    check("ignored_start_product", 32'(cap), 32'hFFEB);

    // Reset mid-operation aborts without a done pulse
    issue(8'h07, 8'hFD);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    issue(8'h03, 8'h04);
    wait_done(lat, bcnt);
    check("after_abort_product", 32'(product), 32'h000C);
    tick();

`ifdef BOOTH_UNSIGNED_EN
    is_signed = 1'b0;
    issue(8'hFF, 8'hFF);
    wait_done(lat, bcnt);
    check("unsigned_255x255", 32'(product), 32'hFE01);
    check("unsigned_latency", 32'(lat), 32'd5);
    tick();
    is_signed = 1'b1;
    issue(8'hFF, 8'hFF);
    wait_done(lat, bcnt);
    check("signed_ffxff", 32'(product), 32'h0001);
    tick();
`endif

    // Random operands against the integer model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b1;
`endif
      is_signed = rs;
      issue(ra, rb);
      wait_done(lat, bcnt);
      check($sformatf("rand%0d_%0h_x_%0h_s%0d", i, ra, rb, rs), 32'(product), 32'(ref_mul(ra, rb, is_signed)));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(STEPS));
      if (($urandom % 2) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
